// File: rtl/ide_host_pio.sv
// rtl/ide_host_pio.sv - ATA PIO host initiator for single register/data-port cycles
//
// Ports:
//   clk, reset_                  system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (write, cs, addr, wdata)
//   rsp_valid/rsp_rdata/rsp_timeout  one-cycle completion with read data / iordy timeout
//   bus_reset                    request an ide_reset_ pulse (sampled in IDLE)
//   irq                          synchronized intrq
//   dd_in/dd_out/dd_oe           split IDE data bus (tristate lives at top level)
//   da, cs1fx_, cs3fx_, dior_, diow_, iordy, intrq, ide_reset_   IDE bus signals
module ide_host_pio #(
    parameter int T_SETUP       = 6,
    parameter int T_ACTIVE      = 14,
    parameter int T_HOLD        = 2,
    parameter int T_RECOVER     = 6,
    parameter int IORDY_TIMEOUT = 1024,
    parameter int RESET_CYCLES  = 2048
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_cs,
    input  logic [2:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_timeout,
    input  logic        bus_reset,
    output logic        irq,
    input  logic [15:0] dd_in,
    output logic [15:0] dd_out,
    output logic        dd_oe,
    output logic [2:0]  da,
    output logic        cs1fx_,
    output logic        cs3fx_,
    output logic        dior_,
    output logic        diow_,
    input  logic        iordy,
    input  logic        intrq,
    output logic        ide_reset_
);

    localparam logic [7:0]  L_SETUP   = 8'(T_SETUP - 1);
    localparam logic [7:0]  L_ACTIVE  = 8'(T_ACTIVE - 1);
    localparam logic [7:0]  L_HOLD    = 8'(T_HOLD - 1);
    localparam logic [7:0]  L_RECOVER = 8'(T_RECOVER - 1);
    localparam logic [15:0] L_TIMEOUT = 16'(IORDY_TIMEOUT - 1);
    localparam logic [15:0] L_RESET   = 16'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ACTIVE, S_WAIT_RDY, S_HOLD, S_RECOVER, S_BRESET
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic [7:0]  r_phase_cnt;
    logic [15:0] r_long_cnt;
    logic        w_phase_done;
    logic        w_long_done;
    logic        r_cmd_ready;
    logic        r_write;
    logic        r_timeout;
    logic [1:0]  r_iordy_sync;
    logic [1:0]  r_intrq_sync;
    logic        w_iordy;

    logic        r_rsp_valid;
    logic [15:0] r_rsp_rdata;
    logic        r_rsp_timeout;
    logic [15:0] r_dd_out;
    logic        r_dd_oe;
    logic [2:0]  r_da;
    logic        r_cs1fx_;
    logic        r_cs3fx_;
    logic        r_dior_;
    logic        r_diow_;
    logic        r_ide_reset_;

    assign w_iordy      = r_iordy_sync[1];
    assign w_phase_done = (r_phase_cnt == 8'd0);
    assign w_long_done  = (r_long_cnt == 16'd0);

    // r_cmd_ready is registered so it reads 0 in the first cycle after reset;
    // a pending bus_reset masks it because bus_reset wins over a command.
    assign cmd_ready   = r_cmd_ready & ~bus_reset;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_timeout = r_rsp_timeout;
    assign irq         = r_intrq_sync[1];
    assign dd_out      = r_dd_out;
    assign dd_oe       = r_dd_oe;
    assign da          = r_da;
    assign cs1fx_      = r_cs1fx_;
    assign cs3fx_      = r_cs3fx_;
    assign dior_       = r_dior_;
    assign diow_       = r_diow_;
    assign ide_reset_  = r_ide_reset_;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus_reset) begin
                    w_next = S_BRESET;
                end else if (cmd_valid && r_cmd_ready) begin
                    w_accept = 1'b1;
                    w_next   = S_SETUP;
                end
            end
            S_SETUP:    if (w_phase_done) w_next = S_ACTIVE;
            S_ACTIVE:   if (w_phase_done) w_next = w_iordy ? S_HOLD : S_WAIT_RDY;
            S_WAIT_RDY: if (w_iordy || w_long_done) w_next = S_HOLD;
            S_HOLD:     if (w_phase_done) w_next = S_RECOVER;
            S_RECOVER:  if (w_phase_done) w_next = S_IDLE;
            S_BRESET:   if (w_long_done) w_next = S_RECOVER;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_phase_cnt   <= 8'd0;
            r_long_cnt    <= 16'd0;
            r_cmd_ready   <= 1'b0;
            r_write       <= 1'b0;
            r_timeout     <= 1'b0;
            r_iordy_sync  <= 2'b00;
            r_intrq_sync  <= 2'b00;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 16'd0;
            r_rsp_timeout <= 1'b0;
            r_dd_out      <= 16'd0;
            r_dd_oe       <= 1'b0;
            r_da          <= 3'd0;
            r_cs1fx_      <= 1'b1;
            r_cs3fx_      <= 1'b1;
            r_dior_       <= 1'b1;
            r_diow_       <= 1'b1;
            r_ide_reset_  <= 1'b1;
        end else begin
            r_iordy_sync  <= {r_iordy_sync[0], iordy};
            r_intrq_sync  <= {r_intrq_sync[0], intrq};
            r_cmd_ready   <= (w_next == S_IDLE);
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;

            // Phase counter reloads on every state change and counts down to 0.
            if (w_next != r_state) begin
                case (w_next)
                    S_SETUP:   r_phase_cnt <= L_SETUP;
                    S_ACTIVE:  r_phase_cnt <= L_ACTIVE;
                    S_HOLD:    r_phase_cnt <= L_HOLD;
                    S_RECOVER: r_phase_cnt <= L_RECOVER;
                    default:   r_phase_cnt <= 8'd0;
                endcase
            end else if (!w_phase_done) begin
                r_phase_cnt <= r_phase_cnt - 8'd1;
            end

            // Shared long counter: iordy extension budget or reset pulse length.
            if (w_next == S_WAIT_RDY && r_state != S_WAIT_RDY) begin
                r_long_cnt <= L_TIMEOUT;
            end else if (w_next == S_BRESET && r_state != S_BRESET) begin
                r_long_cnt <= L_RESET;
            end else if (!w_long_done) begin
                r_long_cnt <= r_long_cnt - 16'd1;
            end

            if (w_accept) begin
                r_write   <= cmd_write;
                r_timeout <= 1'b0;
                r_da      <= cmd_addr;
                r_cs1fx_  <= ~cmd_cs[0];
                r_cs3fx_  <= ~cmd_cs[1];
                r_dd_out  <= cmd_write ? cmd_wdata : 16'd0;
                r_dd_oe   <= cmd_write;
            end

            if (r_state == S_SETUP && w_next == S_ACTIVE) begin
                if (r_write) r_diow_ <= 1'b0;
                else         r_dior_ <= 1'b0;
            end

            // Budget ran out with iordy still low: finish the cycle, flag it.
            if (r_state == S_WAIT_RDY && w_next == S_HOLD && !w_iordy) begin
                r_timeout <= 1'b1;
            end

            // Strobe rises on this edge; dd_in is still the last strobe-low value.
            if (w_next == S_HOLD && r_state != S_HOLD) begin
                r_dior_     <= 1'b1;
                r_diow_     <= 1'b1;
                r_rsp_rdata <= r_write ? 16'd0 : dd_in;
            end

            if (r_state == S_HOLD && w_next == S_RECOVER) begin
                r_cs1fx_      <= 1'b1;
                r_cs3fx_      <= 1'b1;
                r_dd_oe       <= 1'b0;
                r_dd_out      <= 16'd0;
                r_rsp_valid   <= 1'b1;
                r_rsp_timeout <= r_timeout;
            end

            if (r_state == S_IDLE && w_next == S_BRESET) begin
                r_ide_reset_ <= 1'b0;
            end
            if (r_state == S_BRESET && w_next == S_RECOVER) begin
                r_ide_reset_ <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ide_host_pio.sv
// tb/tb_ide_host_pio.sv - self-checking bench for ide_host_pio
module tb_ide_host_pio;

    localparam int T_SETUP      = 6;
    localparam int T_ACTIVE     = 14;
    localparam int T_HOLD       = 2;
    localparam int T_RECOVER    = 6;
    localparam int RESET_CYCLES = 2048;
    localparam int TO_DEFAULT   = 1024;
    localparam int TO_SHORT     = 16;
    localparam int SYNC_LAT     = 2;
    localparam int LIMIT        = 4000;
    localparam int STUCK        = 100000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_, cmd_valid_d, cmd_valid_t, cmd_write, bus_reset, iordy, intrq;
    logic [1:0]  cmd_cs;
    logic [2:0]  cmd_addr;
    logic [15:0] cmd_wdata, dd_in;

    logic        cmd_ready_d, rsp_valid_d, rsp_timeout_d, irq_d, dd_oe_d;
    logic        cs1_d, cs3_d, dior_d, diow_d, ide_reset_d;
    logic [15:0] rsp_rdata_d, dd_out_d;
    logic [2:0]  da_d;
    logic        cmd_ready_t, rsp_valid_t, rsp_timeout_t, irq_t, dd_oe_t;
    logic        cs1_t, cs3_t, dior_t, diow_t, ide_reset_t;
    logic [15:0] rsp_rdata_t, dd_out_t;
    logic [2:0]  da_t;

    ide_host_pio dut (
        .clk(clk), .reset_(reset_), .cmd_valid(cmd_valid_d), .cmd_ready(cmd_ready_d),
        .cmd_write(cmd_write), .cmd_cs(cmd_cs), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_d), .rsp_rdata(rsp_rdata_d), .rsp_timeout(rsp_timeout_d),
        .bus_reset(bus_reset), .irq(irq_d), .dd_in(dd_in), .dd_out(dd_out_d), .dd_oe(dd_oe_d),
        .da(da_d), .cs1fx_(cs1_d), .cs3fx_(cs3_d), .dior_(dior_d), .diow_(diow_d),
        .iordy(iordy), .intrq(intrq), .ide_reset_(ide_reset_d)
    );

    ide_host_pio #(.IORDY_TIMEOUT(TO_SHORT)) dut_t (
        .clk(clk), .reset_(reset_), .cmd_valid(cmd_valid_t), .cmd_ready(cmd_ready_t),
        .cmd_write(cmd_write), .cmd_cs(cmd_cs), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_t), .rsp_rdata(rsp_rdata_t), .rsp_timeout(rsp_timeout_t),
        .bus_reset(bus_reset), .irq(irq_t), .dd_in(dd_in), .dd_out(dd_out_t), .dd_oe(dd_oe_t),
        .da(da_t), .cs1fx_(cs1_t), .cs3fx_(cs3_t), .dior_(dior_t), .diow_(diow_t),
        .iordy(iordy), .intrq(intrq), .ide_reset_(ide_reset_t)
    );

    int checks = 0;
    int failures = 0;

    // Observed instance selector
    logic        use_t;
    logic        m_ready, m_rsp_valid, m_rsp_timeout, m_oe, m_cs1, m_cs3, m_dior, m_diow;
    logic [15:0] m_rsp_rdata, m_dd_out;
    logic [2:0]  m_da_now;
    always_comb begin
        m_ready       = use_t ? cmd_ready_t   : cmd_ready_d;
        m_rsp_valid   = use_t ? rsp_valid_t   : rsp_valid_d;
        m_rsp_timeout = use_t ? rsp_timeout_t : rsp_timeout_d;
        m_rsp_rdata   = use_t ? rsp_rdata_t   : rsp_rdata_d;
        m_oe          = use_t ? dd_oe_t       : dd_oe_d;
        m_dd_out      = use_t ? dd_out_t      : dd_out_d;
        m_da_now      = use_t ? da_t          : da_d;
        m_cs1         = use_t ? cs1_t         : cs1_d;
        m_cs3         = use_t ? cs3_t         : cs3_d;
        m_dior        = use_t ? dior_t        : dior_d;
        m_diow        = use_t ? diow_t        : diow_d;
    end

    // Measurements of one command, cycle 0 = acceptance cycle
    int          r_cs_cyc, r_start, r_len, r_rsp_cyc, r_ready_cyc, r_rsp_count;
    logic [2:0]  r_da;
    logic        r_cs1, r_cs3, r_oe_at_cs, r_timeout, r_oe_bad, r_both_low, r_done;
    logic [15:0] r_dd_out_at_cs, r_rdata;

    // Reference model: strobe-low length and timeout from the bus timing rules.
    // iordy released at offset L is seen SYNC_LAT edges later and the strobe
    // rises on the following edge.
    function automatic int exp_low(input int low_len, input int to);
        int need;
        need = (low_len > 0) ? low_len + SYNC_LAT + 1 : 0;
        if (need <= T_ACTIVE) return T_ACTIVE;
        if (need > T_ACTIVE + to) return T_ACTIVE + to;
        return need;
    endfunction

    function automatic logic exp_to(input int low_len, input int to);
        return (low_len > 0) && (low_len + SYNC_LAT + 1 > T_ACTIVE + to);
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!m_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic issue(input logic t, input logic wr, input logic [1:0] cs, input logic [2:0] addr,
                         input logic [15:0] wdata, input logic [15:0] dev, input int low_len);
        logic seen, ended;
        use_t = t;
        r_cs_cyc = -1; r_start = -1; r_len = 0; r_rsp_cyc = -1; r_ready_cyc = -1; r_rsp_count = 0;
        r_oe_bad = 0; r_both_low = 0; r_done = 0; r_timeout = 0; r_rdata = 16'hDEAD;
        r_da = 0; r_cs1 = 1; r_cs3 = 1; r_oe_at_cs = 0; r_dd_out_at_cs = 0;
        seen = 0; ended = 0;
        wait_ready();
        cmd_write = wr; cmd_cs = cs; cmd_addr = addr; cmd_wdata = wdata;
        if (t) cmd_valid_t = 1'b1; else cmd_valid_d = 1'b1;
        @(negedge clk);
        cmd_valid_d = 1'b0; cmd_valid_t = 1'b0;
        for (int cyc = 1; cyc < LIMIT; cyc++) begin
            if (r_cs_cyc < 0 && (!m_cs1 || !m_cs3)) begin
                r_cs_cyc = cyc; r_da = m_da_now; r_cs1 = m_cs1; r_cs3 = m_cs3;
                r_oe_at_cs = m_oe; r_dd_out_at_cs = m_dd_out;
            end
            if (!m_dior && !m_diow) r_both_low = 1;
            if (m_oe && (!wr || !m_dior)) r_oe_bad = 1;
            if (!(wr ? m_diow : m_dior)) begin
                if (!seen) begin
                    seen = 1; r_start = cyc;
                    if (low_len > 0) iordy = 1'b0;
                end
                if (!ended) r_len++;
            end else if (seen) begin
                ended = 1;
            end
            if (seen && low_len > 0 && cyc == r_start + low_len) iordy = 1'b1;
            dd_in = !m_dior ? dev : 16'($urandom);
            if (m_rsp_valid) begin
                r_rsp_count++; r_rsp_cyc = cyc; r_rdata = m_rsp_rdata; r_timeout = m_rsp_timeout;
            end
            if (r_rsp_count > 0 && m_ready) begin
                r_ready_cyc = cyc; r_done = 1;
                break;
            end
            @(negedge clk);
        end
        iordy = 1'b1;
    endtask

    task automatic test_reset();
        use_t = 0;
        #1;
        checks++; if (m_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=0", m_ready); end
        checks++; if ({m_rsp_valid, m_rsp_timeout, m_oe, irq_d} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {m_rsp_valid, m_rsp_timeout, m_oe, irq_d});
        end
        checks++; if ({m_rsp_rdata, m_dd_out, m_da_now} !== 35'd0) begin
            failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", m_rsp_rdata, m_dd_out, m_da_now);
        end
        checks++; if ({m_cs1, m_cs3, m_dior, m_diow, ide_reset_d} !== 5'b11111) begin
            failures++; $display("FAIL reset_bus got=%b exp=11111", {m_cs1, m_cs3, m_dior, m_diow, ide_reset_d});
        end
    endtask

    task automatic test_write();
        int s;
        issue(0, 1, 2'b01, 3'd7, 16'h00A0, 16'h0, 0);
        s = 1 + T_SETUP;
        checks++; if (r_done !== 1'b1) begin failures++; $display("FAIL wr_done got=%b exp=1", r_done); end
        checks++; if (r_cs_cyc != 1) begin failures++; $display("FAIL wr_cs_cycle got=%0d exp=1", r_cs_cyc); end
        checks++; if ({r_da, r_cs1, r_cs3, r_oe_at_cs} !== {3'd7, 1'b0, 1'b1, 1'b1}) begin
            failures++; $display("FAIL wr_addr_cs got=da%0d cs%b%b oe%b exp=da7 cs01 oe1", r_da, r_cs1, r_cs3, r_oe_at_cs);
        end
        checks++; if (r_dd_out_at_cs !== 16'h00A0) begin failures++; $display("FAIL wr_dd_out got=%h exp=00a0", r_dd_out_at_cs); end
        checks++; if (r_start != s || r_len != T_ACTIVE) begin
            failures++; $display("FAIL wr_strobe got=start%0d len%0d exp=start%0d len%0d", r_start, r_len, s, T_ACTIVE);
        end
        checks++; if (r_rsp_cyc != s + T_ACTIVE + T_HOLD || r_timeout !== 1'b0 || r_rdata !== 16'h0) begin
            failures++; $display("FAIL wr_rsp got=cyc%0d to%b rd%h exp=cyc%0d to0 rd0000", r_rsp_cyc, r_timeout, r_rdata, s + T_ACTIVE + T_HOLD);
        end
        checks++; if (r_ready_cyc != r_rsp_cyc + T_RECOVER) begin
            failures++; $display("FAIL wr_ready got=%0d exp=%0d", r_ready_cyc, r_rsp_cyc + T_RECOVER);
        end
    endtask

    task automatic test_read();
        issue(0, 0, 2'b10, 3'd6, 16'hFFFF, 16'h1234, 0);
        checks++; if (r_rdata !== 16'h1234 || r_rsp_count != 1) begin
            failures++; $display("FAIL rd_data got=%h n%0d exp=1234 n1", r_rdata, r_rsp_count);
        end
        checks++; if ({r_da, r_cs1, r_cs3} !== {3'd6, 1'b1, 1'b0}) begin
            failures++; $display("FAIL rd_cs got=da%0d cs%b%b exp=da6 cs10", r_da, r_cs1, r_cs3);
        end
        checks++; if (r_oe_bad !== 1'b0 || r_both_low !== 1'b0) begin
            failures++; $display("FAIL rd_oe got=oe_bad%b both%b exp=00", r_oe_bad, r_both_low);
        end
        checks++; if (r_len != T_ACTIVE) begin failures++; $display("FAIL rd_len got=%0d exp=%0d", r_len, T_ACTIVE); end
    endtask

    task automatic test_iordy_ext();
        logic [15:0] dev;
        dev = 16'($urandom);
        issue(0, 0, 2'b01, 3'd0, 16'h0, dev, 40);
        checks++; if (r_len != exp_low(40, TO_DEFAULT)) begin
            failures++; $display("FAIL ext_len got=%0d exp=%0d", r_len, exp_low(40, TO_DEFAULT));
        end
        checks++; if (r_rdata !== dev || r_timeout !== 1'b0) begin
            failures++; $display("FAIL ext_rsp got=%h to%b exp=%h to0", r_rdata, r_timeout, dev);
        end
    endtask

    task automatic test_timeout();
        issue(1, 0, 2'b10, 3'd3, 16'h0, 16'h5A5A, STUCK);
        checks++; if (r_len != T_ACTIVE + TO_SHORT || r_timeout !== 1'b1) begin
            failures++; $display("FAIL to_len got=%0d to%b exp=%0d to1", r_len, r_timeout, T_ACTIVE + TO_SHORT);
        end
        checks++; if (r_rsp_cyc != 1 + T_SETUP + T_ACTIVE + TO_SHORT + T_HOLD) begin
            failures++; $display("FAIL to_rsp_cyc got=%0d exp=%0d", r_rsp_cyc, 1 + T_SETUP + T_ACTIVE + TO_SHORT + T_HOLD);
        end
        issue(1, 1, 2'b01, 3'd1, 16'hBEEF, 16'h0, 0);
        checks++; if (r_len != T_ACTIVE || r_timeout !== 1'b0 || r_done !== 1'b1) begin
            failures++; $display("FAIL to_next got=len%0d to%b done%b exp=len%0d to0 done1", r_len, r_timeout, r_done, T_ACTIVE);
        end
    endtask

    task automatic test_bus_reset();
        int low_cnt, cs_cyc, rsp_pre, rsp_all;
        logic ready_bad;
        low_cnt = 0; cs_cyc = -1; rsp_pre = 0; rsp_all = 0; ready_bad = 0;
        use_t = 0;
        wait_ready();
        bus_reset = 1'b1;
        cmd_write = 1'b1; cmd_cs = 2'b01; cmd_addr = 3'd2; cmd_wdata = 16'h0C0C; cmd_valid_d = 1'b1;
        @(negedge clk);
        bus_reset = 1'b0;
        for (int cyc = 1; cyc < LIMIT; cyc++) begin
            if (!ide_reset_d) low_cnt++;
            if (m_rsp_valid) begin
                rsp_all++;
                if (cs_cyc < 0) rsp_pre++;
            end
            if (cs_cyc < 0 && m_ready && cyc <= RESET_CYCLES + T_RECOVER) ready_bad = 1;
            if (cs_cyc < 0 && !m_cs1) begin
                cs_cyc = cyc;
                cmd_valid_d = 1'b0;
            end
            if (cs_cyc > 0 && rsp_all > 0 && m_ready) break;
            @(negedge clk);
        end
        cmd_valid_d = 1'b0;
        checks++; if (low_cnt != RESET_CYCLES) begin failures++; $display("FAIL br_low got=%0d exp=%0d", low_cnt, RESET_CYCLES); end
        checks++; if (cs_cyc != RESET_CYCLES + T_RECOVER + 2) begin
            failures++; $display("FAIL br_accept got=%0d exp=%0d", cs_cyc, RESET_CYCLES + T_RECOVER + 2);
        end
        checks++; if (rsp_pre != 0 || rsp_all != 1 || ready_bad !== 1'b0) begin
            failures++; $display("FAIL br_rsp got=pre%0d all%0d rdy_bad%b exp=pre0 all1 rdy_bad0", rsp_pre, rsp_all, ready_bad);
        end
    endtask

    task automatic test_random();
        logic t, wr;
        logic [1:0] cs;
        logic [2:0] addr;
        logic [15:0] wd, dev;
        int low, to, s;
        for (int i = 0; i < 10; i++) begin
            t = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
            cs = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
            addr = 3'($urandom); wd = 16'($urandom); dev = 16'($urandom);
            low = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 60)) : 0;
            to = t ? TO_SHORT : TO_DEFAULT;
            s = 1 + T_SETUP;
            issue(t, wr, cs, addr, wd, dev, low);
            checks++; if (r_len != exp_low(low, to) || r_timeout !== exp_to(low, to)) begin
                failures++; $display("FAIL rnd%0d_len got=%0d to%b exp=%0d to%b", i, r_len, r_timeout, exp_low(low, to), exp_to(low, to));
            end
            checks++; if (r_rdata !== (wr ? 16'h0 : dev) || r_rsp_count != 1) begin
                failures++; $display("FAIL rnd%0d_data got=%h n%0d exp=%h n1", i, r_rdata, r_rsp_count, wr ? 16'h0 : dev);
            end
            checks++; if (r_start != s || r_rsp_cyc != s + exp_low(low, to) + T_HOLD || r_ready_cyc != r_rsp_cyc + T_RECOVER) begin
                failures++; $display("FAIL rnd%0d_timing got=%0d/%0d/%0d exp_start=%0d", i, r_start, r_rsp_cyc, r_ready_cyc, s);
            end
            checks++; if (r_da !== addr || {r_cs3, r_cs1} !== ~cs || r_oe_at_cs !== wr || r_oe_bad || r_both_low) begin
                failures++; $display("FAIL rnd%0d_bus got=da%0d cs%b%b oe%b bad%b%b exp=da%0d", i, r_da, r_cs3, r_cs1, r_oe_at_cs, r_oe_bad, r_both_low, addr);
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        use_t = 0;
        wait_ready();
        cmd_write = 1'b1; cmd_cs = 2'b01; cmd_addr = 3'd5; cmd_wdata = 16'h7777; cmd_valid_d = 1'b1;
        @(negedge clk);
        cmd_valid_d = 1'b0;
        n = 0;
        while (m_diow && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        #2 reset_ = 1'b0;
        #1;
        checks++; if ({m_diow, m_dior, m_cs1, m_cs3, m_oe} !== 5'b11110 || n >= 100) begin
            failures++; $display("FAIL ar_bus got=%b n%0d exp=11110", {m_diow, m_dior, m_cs1, m_cs3, m_oe}, n);
        end
        @(negedge clk);
        checks++; if (m_ready !== 1'b0 || m_rsp_valid !== 1'b0) begin
            failures++; $display("FAIL ar_hold got=rdy%b rsp%b exp=00", m_ready, m_rsp_valid);
        end
        reset_ = 1'b1;
        intrq = 1'b1;
        @(negedge clk);
        intrq = 1'b0;
        checks++; if (m_ready !== 1'b1 || irq_d !== 1'b0) begin
            failures++; $display("FAIL ar_release got=rdy%b irq%b exp=rdy1 irq0", m_ready, irq_d);
        end
        @(negedge clk);
        checks++; if (irq_d !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq_d); end
        @(negedge clk);
        checks++; if (irq_d !== 1'b0 || m_rsp_valid !== 1'b0) begin
            failures++; $display("FAIL irq_fall got=irq%b rsp%b exp=00", irq_d, m_rsp_valid);
        end
    endtask

    initial begin
        reset_ = 1'b0; cmd_valid_d = 1'b0; cmd_valid_t = 1'b0; cmd_write = 1'b0; cmd_cs = 2'b01;
        cmd_addr = 3'd0; cmd_wdata = 16'h0; bus_reset = 1'b0; iordy = 1'b1; intrq = 1'b0;
        dd_in = 16'h0; use_t = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_ = 1'b1;
        test_write();
        test_read();
        test_iordy_ext();
        test_timeout();
        test_bus_reset();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ide_host_pio.md
Name: ide_host_pio

Overview:
- ATA PIO host initiator: performs single register/data-port read and write cycles on an IDE bus toward a device such as ide_interface.
- Used for hardware loopback and bring-up of the drive emulation on a second board, or with a jumpered header.
- Driven by a simple command/response handshake from a CPU-side wrapper.
- IDE data bus is split into dd_in/dd_out/dd_oe; the tristate buffer is instantiated at top level.

Parameters:
- T_SETUP, 6: clk cycles address/CS valid before strobe falls (t1); range 1..255.
- T_ACTIVE, 14: minimum clk cycles strobe is low (t2); range 1..255.
- T_HOLD, 2: clk cycles address/CS/write data held after strobe rises; range 1..255.
- T_RECOVER, 6: clk cycles of idle bus before the next command is accepted (t2i); range 1..255.
- IORDY_TIMEOUT, 1024: maximum extension cycles waiting for iordy; range 1..65535.
- RESET_CYCLES, 2048: length of ide_reset_ low pulse; range 1..65535.

Ports:
- clk  in  1  system clock (clkout domain)
- reset_  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write cycle, 0 = read cycle
- cmd_cs  in  2  {cs3fx select, cs1fx select}; exactly one bit set
- cmd_addr  in  3  register address (da)
- cmd_wdata  in  16  write data
- rsp_valid  out  1  one-cycle pulse: cycle complete
- rsp_rdata  out  16  captured read data; 0 for writes
- rsp_timeout  out  1  valid with rsp_valid: iordy timeout occurred
- bus_reset  in  1  request hardware reset pulse (level, sampled in IDLE)
- irq  out  1  intrq after 2-FF synchronizer
- dd_in  in  16  IDE data from pads
- dd_out  out  16  IDE data to pads
- dd_oe  out  1  drive dd_out onto bus
- da  out  3  IDE address
- cs1fx_  out  1  chip select 0, active low
- cs3fx_  out  1  chip select 1, active low
- dior_  out  1  read strobe, active low
- diow_  out  1  write strobe, active low
- iordy  in  1  device ready; asynchronous, 2-FF synchronized internally
- intrq  in  1  device interrupt; asynchronous
- ide_reset_  out  1  IDE bus reset, active low

Behaviour:
- Reset values: cmd_ready=0; rsp_valid=0; rsp_rdata=0; rsp_timeout=0; irq=0; dd_out=0; dd_oe=0; da=0; cs1fx_=cs3fx_=dior_=diow_=1; ide_reset_=1. The FSM enters IDLE.
- States: IDLE, SETUP, ACTIVE, WAIT_RDY, HOLD, RECOVER, BRESET.
- IDLE:
  - cmd_ready=1.
  - bus_reset has priority over cmd_valid: go to BRESET.
  - Otherwise, on cmd_valid, latch cmd_* on the acceptance edge. Drive da and CSes (cs1fx_=~cmd_cs[0], cs3fx_=~cmd_cs[1]). For writes, also drive dd_out=wdata and dd_oe=1. Go to SETUP.
- SETUP: count T_SETUP cycles, then go to ACTIVE with the strobe (dior_ or diow_) low.
- ACTIVE:
  - Count T_ACTIVE cycles.
  - On the last cycle, test synchronized iordy. If 1, go to HOLD. If 0, go to WAIT_RDY.
- WAIT_RDY:
  - Strobe stays low.
  - Exit to HOLD on the first cycle synchronized iordy=1.
  - If IORDY_TIMEOUT cycles elapse, set a timeout flag and go to HOLD.
- Entering HOLD:
  - Strobe rises on the same edge.
  - For reads, rsp_rdata <= dd_in sampled on that edge (last strobe-low cycle).
  - Hold address, CS and dd_oe for T_HOLD cycles.
- Entering RECOVER:
  - Deassert CSes; dd_oe=0; dd_out=0.
  - Pulse rsp_valid for one cycle, with rsp_timeout=flag.
  - Stay T_RECOVER cycles, then go to IDLE.
- Strobe low time: exactly T_ACTIVE cycles plus any extension. Command-to-rsp_valid latency: T_SETUP+T_ACTIVE+ext+T_HOLD+1 cycles after acceptance.
- BRESET:
  - ide_reset_=0 for RESET_CYCLES cycles, then 1.
  - Then RECOVER (no rsp_valid pulse).
  - cmd_ready=0 throughout.
- cmd_valid outside IDLE is ignored; the command stays pending until cmd_ready.
- Counters: 8-bit phase counter and 16-bit timeout/reset counter. All count down from parameter−1 to 0; no wrap possible.
- Asynchronous reset mid-cycle: all strobes and CSes immediately return to 1, dd_oe=0, and no rsp_valid is issued.
- irq follows intrq with 2-cycle latency. It is independent of the FSM and live in every state.
- Invariants, every cycle:
  - dior_ and diow_ are never both 0.
  - dd_oe=1 only during write cycles.
  - dd_oe=0 whenever dior_=0.

Test Plan:
- Write with cmd_cs=01, addr=7, wdata=0x00A0, iordy=1, default params:
  - cs1fx_=0, da=7 and dd_oe=1 at acceptance+1.
  - diow_ low exactly 14 cycles, starting 6 cycles after CS.
  - rsp_valid after 23 cycles, rsp_timeout=0.
  - cmd_ready re-asserts 6 cycles later.
- Read with cmd_cs=10, addr=6, device drives 0x1234 while dior_=0:
  - rsp_rdata=0x1234, cs3fx_=0 only, dd_oe=0 throughout.
- Read with iordy held low for 40 cycles from strobe fall:
  - dior_ low ~40 cycles plus synchronizer delay.
  - Data captured after iordy rises; rsp_timeout=0.
- iordy stuck low with IORDY_TIMEOUT=16:
  - Strobe low 14+16 cycles; rsp_valid with rsp_timeout=1.
  - Next command works normally.
- bus_reset and cmd_valid both asserted in IDLE:
  - ide_reset_ low exactly 2048 cycles.
  - Command accepted only after BRESET and RECOVER.
  - No rsp_valid from the reset.
- reset_ asserted mid-ACTIVE of a write:
  - diow_, cs1fx_ and cs3fx_ go to 1 and dd_oe to 0 asynchronously.
  - After release, cmd_ready=1 on the next cycle; intrq pulse appears on irq 2 cycles later.
